// File: rtl/alu_regfile_core.sv
// rtl/alu_regfile_core.sv - register-file ALU core with single-cycle ops and iterative divide/modulo
// Results and flags are registered; DIV/MOD with a nonzero divisor run one quotient bit per cycle.
module alu_regfile_core #(
   parameter int WIDTH = 8,
   parameter int NREGS = 4,
   localparam int AW = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [AW-1:0]    rd,
   input  logic [AW-1:0]    rs1,
   input  logic [AW-1:0]    rs2,
   input  logic [WIDTH-1:0] imm,
   output logic             out_valid,
   output logic [AW-1:0]    out_rd,
   output logic [WIDTH-1:0] result,
   output logic             zero_flag,
   output logic             carry_flag,
   output logic             overflow_flag,
   output logic             div_zero,
   output logic             busy
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_MUL = 4'd2,  OP_DIV = 4'd3;
   localparam logic [3:0] OP_MOD = 4'd4,  OP_AND = 4'd5,  OP_OR  = 4'd6,  OP_XOR = 4'd7;
   localparam logic [3:0] OP_NOT = 4'd8,  OP_GT  = 4'd9,  OP_GE  = 4'd10, OP_LT  = 4'd11;
   localparam logic [3:0] OP_LE  = 4'd12, OP_EQ  = 4'd13, OP_NE  = 4'd14, OP_LDI = 4'd15;

   typedef enum logic {S_IDLE, S_DIV} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] reg_q [NREGS];
   logic [WIDTH-1:0] reg_d [NREGS];
   logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic [AW-1:0]    div_rd_q, div_rd_d;
   logic             div_mod_q, div_mod_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic [AW-1:0]    out_rd_q, out_rd_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, dz_q, dz_d;

   logic [WIDTH-1:0]   a, b, res, rem_next, quo_next;
   logic [WIDTH:0]     sum, diff, trial;
   logic [2*WIDTH-1:0] prod;
   logic               c, ov, dz, ge, is_div;

   always_comb begin
      a    = reg_q[rs1];
      b    = reg_q[rs2];
      sum  = {1'b0, a} + {1'b0, b};
      diff = {1'b0, a} - {1'b0, b};
      prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      res  = '0;
      c    = 1'b0;
      ov   = 1'b0;
      dz   = 1'b0;
      case (op)
         OP_ADD: begin
            res = sum[WIDTH-1:0];
            c   = sum[WIDTH];
            ov  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            res = diff[WIDTH-1:0];
            c   = diff[WIDTH];
            ov  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_MUL: begin
            res = prod[WIDTH-1:0];
            c   = |prod[2*WIDTH-1:WIDTH];
         end
         // Only the divide-by-zero case completes here; nonzero divisors go to the iterative path.
         OP_DIV: begin res = '1; dz = 1'b1; end
         OP_MOD: begin res = a;  dz = 1'b1; end
         OP_AND: res = a & b;
         OP_OR:  res = a | b;
         OP_XOR: res = a ^ b;
         OP_NOT: res = ~a;
         OP_GT:  res = {{(WIDTH-1){1'b0}}, a >  b};
         OP_GE:  res = {{(WIDTH-1){1'b0}}, a >= b};
         OP_LT:  res = {{(WIDTH-1){1'b0}}, a <  b};
         OP_LE:  res = {{(WIDTH-1){1'b0}}, a <= b};
         OP_EQ:  res = {{(WIDTH-1){1'b0}}, a == b};
         OP_NE:  res = {{(WIDTH-1){1'b0}}, a != b};
         default: res = imm;
      endcase
      is_div = (op == OP_DIV) || (op == OP_MOD);

      // Restoring step: shift the next dividend bit into the partial remainder.
      trial    = {rem_q, quo_q[WIDTH-1]};
      ge       = trial >= {1'b0, dvs_q};
      rem_next = ge ? (trial[WIDTH-1:0] - dvs_q) : trial[WIDTH-1:0];
      quo_next = {quo_q[WIDTH-2:0], ge};
   end

   always_comb begin
      state_d     = state_q;
      reg_d       = reg_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dvs_d       = dvs_q;
      div_rd_d    = div_rd_q;
      div_mod_d   = div_mod_q;
      cnt_d       = cnt_q;
      out_valid_d = 1'b0;
      out_rd_d    = out_rd_q;
      result_d    = result_q;
      zero_d      = zero_q;
      carry_d     = carry_q;
      ovf_d       = ovf_q;
      dz_d        = dz_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (is_div && (b != '0)) begin
                  state_d   = S_DIV;
                  rem_d     = '0;
                  quo_d     = a;
                  dvs_d     = b;
                  div_rd_d  = rd;
                  div_mod_d = (op == OP_MOD);
                  cnt_d     = '0;
               end else begin
                  reg_d[rd]   = res;
                  out_valid_d = 1'b1;
                  out_rd_d    = rd;
                  result_d    = res;
                  zero_d      = (res == '0);
                  carry_d     = c;
                  ovf_d       = ov;
                  dz_d        = dz;
               end
            end
         end
         default: begin
            rem_d = rem_next;
            quo_d = quo_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d          = S_IDLE;
               reg_d[div_rd_q]  = div_mod_q ? rem_next : quo_next;
               out_valid_d      = 1'b1;
               out_rd_d         = div_rd_q;
               result_d         = div_mod_q ? rem_next : quo_next;
               zero_d           = ((div_mod_q ? rem_next : quo_next) == '0);
               carry_d          = 1'b0;
               ovf_d            = 1'b0;
               dz_d             = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         for (int i = 0; i < NREGS; i++) reg_q[i] <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         div_rd_q    <= '0;
         div_mod_q   <= 1'b0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_rd_q    <= '0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
         dz_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         reg_q       <= reg_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dvs_q       <= dvs_d;
         div_rd_q    <= div_rd_d;
         div_mod_q   <= div_mod_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_rd_q    <= out_rd_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         carry_q     <= carry_d;
         ovf_q       <= ovf_d;
         dz_q        <= dz_d;
      end
   end

   assign in_ready      = (state_q == S_IDLE);
   assign busy          = (state_q == S_DIV);
   assign out_valid     = out_valid_q;
   assign out_rd        = out_rd_q;
   assign result        = result_q;
   assign zero_flag     = zero_q;
   assign carry_flag    = carry_q;
   assign overflow_flag = ovf_q;
   assign div_zero      = dz_q;
endmodule

// File: tb/tb_alu_regfile_core.sv
// tb/tb_alu_regfile_core.sv - randomized bench for alu_regfile_core against an arithmetic reference model
// Directed sequence first, then random instructions; a mid-divide reset is exercised in between.
module tb_alu_regfile_core;
   localparam int W  = 8;
   localparam int N  = 4;
   localparam int AW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    op;
   logic [AW-1:0] rd, rs1, rs2;
   logic [W-1:0]  imm;
   logic          out_valid;
   logic [AW-1:0] out_rd;
   logic [W-1:0]  result;
   logic          zero_flag, carry_flag, overflow_flag, div_zero, busy;

   int checks   = 0;
   int failures = 0;
   logic [W-1:0] mreg [N];

   alu_regfile_core #(.WIDTH(W), .NREGS(N)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
      .out_valid(out_valid), .out_rd(out_rd), .result(result),
      .zero_flag(zero_flag), .carry_flag(carry_flag), .overflow_flag(overflow_flag),
      .div_zero(div_zero), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int to_signed(input logic [W-1:0] v);
      return v[W-1] ? int'(v) - (1 << W) : int'(v);
   endfunction

   task automatic model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] iv, output logic [W-1:0] r,
                        output logic c, output logic ov, output logic dz);
      int unsigned m, ua, ub;
      longint unsigned p;
      int s;
      m = (1 << W) - 1;
      ua = int'(a);
      ub = int'(b);
      c = 0; ov = 0; dz = 0; r = '0;
      case (o)
         0: begin r = W'(ua + ub); c = (ua + ub) > m;
            s = to_signed(a) + to_signed(b); ov = (s > 127) || (s < -128); end
         1: begin r = W'(ua - ub); c = ua < ub;
            s = to_signed(a) - to_signed(b); ov = (s > 127) || (s < -128); end
         2: begin p = longint'(ua) * longint'(ub); r = W'(p); c = (p >> W) != 0; end
         3: begin if (ub == 0) begin r = W'(m); dz = 1; end else r = W'(ua / ub); end
         4: begin if (ub == 0) begin r = a; dz = 1; end else r = W'(ua % ub); end
         5: r = a & b;
         6: r = a | b;
         7: r = a ^ b;
         8: r = ~a;
         9:  r = W'(ua >  ub);
         10: r = W'(ua >= ub);
         11: r = W'(ua <  ub);
         12: r = W'(ua <= ub);
         13: r = W'(ua == ub);
         14: r = W'(ua != ub);
         default: r = iv;
      endcase
   endtask

   // Called at a falling edge; returns at the falling edge after the result is visible.
   task automatic issue(input logic [3:0] o, input logic [AW-1:0] d, input logic [AW-1:0] s1,
                        input logic [AW-1:0] s2, input logic [W-1:0] iv);
      logic [W-1:0] r;
      logic c, ov, dz;
      bit multi;
      op = o; rd = d; rs1 = s1; rs2 = s2; imm = iv; in_valid = 1'b1;
      check_eq("in_ready_at_issue", in_ready, 1);
      model(o, mreg[s1], mreg[s2], iv, r, c, ov, dz);
      multi = ((o == 3) || (o == 4)) && (mreg[s2] != 0);
      @(posedge clk);
      @(negedge clk);
      if (multi) begin
         for (int k = 0; k < W; k++) begin
            check_eq("div_in_ready", in_ready, 0);
            check_eq("div_busy", busy, 1);
            check_eq("div_out_valid", out_valid, 0);
            op = 4'($urandom); rd = AW'($urandom); rs1 = AW'($urandom);
            rs2 = AW'($urandom); imm = W'($urandom);
            @(negedge clk);
         end
      end
      mreg[d] = r;
      check_eq("out_valid", out_valid, 1);
      check_eq("out_rd", out_rd, d);
      check_eq("result", result, r);
      check_eq("zero_flag", zero_flag, r == 0);
      check_eq("carry_flag", carry_flag, c);
      check_eq("overflow_flag", overflow_flag, ov);
      check_eq("div_zero", div_zero, dz);
      check_eq("busy_after", busy, 0);
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
      for (int i = 0; i < N; i++) mreg[i] = '0;
      #12;
      check_eq("rst_in_ready", in_ready, 1);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_result", result, 0);
      check_eq("rst_flags", {zero_flag, carry_flag, overflow_flag, div_zero, busy}, 0);
      check_eq("rst_out_rd", out_rd, 0);
      @(negedge clk);
      rst = 1'b0;

      issue(15, 0, 0, 0, 8'd5);
      issue(15, 1, 0, 0, 8'd3);
      issue(0, 2, 0, 1, 0);
      check_eq("plan_add", result, 8);
      issue(1, 3, 1, 0, 0);
      check_eq("plan_sub", result, 8'hFE);
      issue(13, 2, 3, 3, 0);
      issue(3, 2, 0, 1, 0);
      check_eq("plan_div", result, 1);
      issue(4, 3, 0, 1, 0);
      check_eq("plan_mod", result, 2);
      issue(15, 1, 0, 0, 8'd0);
      issue(3, 2, 0, 1, 0);
      check_eq("plan_div0", result, 8'hFF);
      issue(4, 3, 0, 1, 0);
      check_eq("plan_mod0", result, 5);
      issue(15, 0, 0, 0, 8'h7F);
      issue(15, 1, 0, 0, 8'h01);
      issue(0, 2, 0, 1, 0);
      issue(15, 0, 0, 0, 8'h10);
      issue(15, 1, 0, 0, 8'h10);
      issue(2, 2, 0, 1, 0);
      @(negedge clk);
      check_eq("idle_out_valid", out_valid, 0);
      check_eq("held_carry", carry_flag, 1);

      // Reset in the middle of a divide.
      issue(15, 0, 0, 0, 8'd200);
      issue(15, 1, 0, 0, 8'd7);
      op = 3; rd = 2; rs1 = 0; rs2 = 1; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("pre_rst_busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      check_eq("arst_in_ready", in_ready, 1);
      check_eq("arst_busy", busy, 0);
      check_eq("arst_result", result, 0);
      check_eq("arst_flags", {out_valid, zero_flag, carry_flag, overflow_flag, div_zero}, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < N; i++) mreg[i] = '0;
      for (int k = 0; k < W + 2; k++) begin
         check_eq("post_rst_no_out", out_valid, 0);
         @(negedge clk);
      end
      for (int i = 0; i < N; i++) issue(6, AW'(i), AW'(i), AW'(i), 0);

      for (int n = 0; n < 400; n++) begin
         logic [3:0] o;
         logic [W-1:0] iv;
         o  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
         iv = ($urandom_range(0, 4) == 0) ? 8'd0 : W'($urandom);
         issue(o, AW'($urandom), AW'($urandom), AW'($urandom), iv);
         if ($urandom_range(0, 7) == 0) begin
            @(negedge clk);
            check_eq("gap_out_valid", out_valid, 0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/alu_regfile_core.md
Name: alu_regfile_core

Overview:
- Parametrised successor of the 8-bit, 3-register, fixed-operand processor: WIDTH-bit datapath, NREGS-entry register file, instruction-selected source and destination registers.
- Accepts one instruction per valid/ready handshake.
- Executes single-cycle ALU ops and multi-cycle iterative divide/modulo.
- Writes the result back to the register file and reports it with registered flags.
- Sits between the instruction sequencer and downstream result consumers.

Parameters:
- WIDTH, 8, datapath and register width (>=4).
- NREGS, 4, register-file depth (>=2, power of two).
- AW, $clog2(NREGS), register address width (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  core can accept an instruction this cycle.
- op  in  4  opcode.
- rd  in  AW  destination register.
- rs1  in  AW  source A register.
- rs2  in  AW  source B register.
- imm  in  WIDTH  immediate for LDI.
- out_valid  out  1  one-cycle pulse: result/flags valid, rd written.
- out_rd  out  AW  destination of the completed instruction.
- result  out  WIDTH  completed result.
- zero_flag  out  1  result == 0.
- carry_flag  out  1  carry/borrow/multiply-high.
- overflow_flag  out  1  signed overflow (ADD/SUB only).
- div_zero  out  1  DIV/MOD with B == 0.
- busy  out  1  multi-cycle operation in progress.

Behaviour:
- Reset: all registers 0; state IDLE; in_ready=1; out_valid=0, out_rd=0, result=0, all flags 0, busy=0. Applies immediately, asynchronously.
- Opcodes (A=reg[rs1], B=reg[rs2]):
  - 0 ADD, 1 SUB, 2 MUL (low WIDTH bits), 3 DIV, 4 MOD.
  - 5 AND, 6 OR, 7 XOR, 8 NOT A.
  - 9 A>B, 10 A>=B, 11 A<B, 12 A<=B, 13 A==B, 14 A!=B. Compares are unsigned; result 1 or 0.
  - 15 LDI (rd<=imm).
- Handshake: accept on a rising edge with in_valid && in_ready.
- States: IDLE, DIV.
- IDLE, non-DIV/MOD op, or DIV/MOD with B==0:
  - At the accept edge, register rd, result, flags, out_rd, and set out_valid=1 for the following cycle.
  - Latency 1. in_ready stays 1, so throughput is 1/cycle.
- IDLE, DIV/MOD with B!=0:
  - At the accept edge, latch A, B, rd, op; go to DIV; in_ready=0, busy=1. out_valid=0 unless a previous single-cycle op completes at this edge.
  - DIV runs a restoring divider, one quotient bit per cycle, WIDTH cycles.
  - On the WIDTH-th edge in DIV: write rd (quotient for DIV, remainder for MOD), out_valid=1, return to IDLE, in_ready=1, busy=0.
  - Latency is WIDTH+1 edges from accept to write-back.
- Divide by zero: DIV result all ones; MOD result = A; div_zero=1; latency 1. div_zero=0 on every other completion.
- Flags update only on completion and hold between completions. Defined per op:
  - ADD: carry = bit WIDTH of A+B; overflow = signed overflow.
  - SUB: carry = borrow (A<B); overflow = signed overflow.
  - MUL: carry = upper WIDTH bits of the full product nonzero; overflow=0.
  - All other ops: carry=0, overflow=0.
  - zero_flag is valid for all ops.
- Hazards: register reads are combinational at accept. A back-to-back instruction reading the previous rd sees the new value, since the write is at the prior edge. Only one write port; no conflicting writes are possible.
- in_valid while in_ready=0: ignored, not queued. The source must hold the instruction.
- Reset during DIV: aborts; no write-back; no out_valid.
- out_valid has no backpressure; consumers must sample it in its cycle.

Test Plan:
- WIDTH=8, NREGS=4; LDI r0,5; LDI r1,3; ADD r2,r0,r1 -> out_valid on 3 consecutive cycles; r2=8, result=8, zero=carry=overflow=0.
- SUB r3,r1,r0 (3-5) -> result=0xFE, carry=1, overflow=0. Then EQ r2,r3,r3 -> result=1.
- DIV r2,r0,r1 (5/3) -> in_ready=0 for 8 cycles, out_valid at edge 9, result=1. MOD r3,r0,r1 -> result=2. in_valid asserted during DIV is ignored.
- LDI r1,0; DIV r2,r0,r1 -> latency 1, result=0xFF, div_zero=1. MOD -> result=5, div_zero=1.
- LDI r0,0x7F; LDI r1,0x01; ADD -> 0x80, overflow=1, carry=0. LDI r0,0x10; LDI r1,0x10; MUL -> 0x00, zero=1, carry=1.
- Start DIV, assert rst at DIV cycle 4 -> all outputs 0, registers 0, in_ready=1 immediately, no out_valid after release.
